// File: rtl/pif_led_seq.sv
// Two-colour LED sequencer: solid, breathe and blink patterns with PWM dimming.
// Commands are accepted over a valid/ready handshake; finite sequences pulse done on completion.
module pif_led_seq #(
    parameter int unsigned TICK_DIV   = 8,
    parameter int unsigned B          = 5,
    parameter int unsigned HOLD_TICKS = 4
) (
    input  logic       osc,
    input  logic       sys_rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_color,
    input  logic [1:0] cmd_mode,
    input  logic [3:0] cmd_repeat,
    output logic       red,
    output logic       green,
    output logic       busy,
    output logic       done
);

    localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_RELOAD = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_ONE    = PW'(1);
    localparam logic [B-1:0]  LVL_MAX      = '1;
    localparam logic [B-1:0]  LVL_ONE      = B'(1);
    localparam logic [7:0]    HOLD_LAST    = 8'(HOLD_TICKS - 1);

    typedef enum logic [2:0] {
        StIdle, StSolid, StUp, StHoldHi, StDown, StHoldLo
    } state_e;

    state_e        state_q, state_d;
    logic [B-1:0]  lvl_q, lvl_d;
    logic [B-1:0]  pwm_q;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [7:0]    hold_q, hold_d;
    logic [1:0]    color_q, color_d;
    logic [1:0]    mode_q, mode_d;
    logic [3:0]    rep_q, rep_d;
    logic          done_q, done_d;
    logic          red_q, red_d;
    logic          green_q, green_d;
    logic          rdy_en_q;

    logic tick, accept, blink, led_on;

    assign tick      = (presc_q == '0);
    assign busy      = (state_q != StIdle);
    // Finite sequences lock out new commands until they finish.
    assign cmd_ready = rdy_en_q & ((state_q == StIdle) | (state_q == StSolid) | (rep_q == 4'd0));
    assign accept    = cmd_valid & cmd_ready;
    assign blink     = (mode_q == 2'd2);
    assign led_on    = (lvl_q == LVL_MAX) | (pwm_q < lvl_q);
    assign red       = red_q;
    assign green     = green_q;
    assign done      = done_q;

    always_comb begin
        state_d = state_q;
        lvl_d   = lvl_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        color_d = color_q;
        mode_d  = mode_q;
        rep_d   = rep_q;
        done_d  = 1'b0;
        presc_d = tick ? PRESC_RELOAD : presc_q - PRESC_ONE;
        red_d   = ~(led_on & color_q[0]);
        green_d = ~(led_on & color_q[1]);

        if (accept) begin
            color_d = cmd_color;
            mode_d  = cmd_mode;
            rep_d   = cmd_repeat;
            cnt_d   = 4'd0;
            hold_d  = 8'd0;
            presc_d = PRESC_RELOAD;
            if (cmd_color == 2'd0) begin
                state_d = StIdle;
                lvl_d   = '0;
                done_d  = (state_q != StIdle);
            end else if ((cmd_mode == 2'd1) || (cmd_mode == 2'd2)) begin
                state_d = StUp;
                lvl_d   = '0;
            end else begin
                state_d = StSolid;
                lvl_d   = LVL_MAX;
            end
        end else if (tick) begin
            unique case (state_q)
                StUp: begin
                    if (blink || (lvl_q == LVL_MAX - LVL_ONE)) begin
                        lvl_d   = LVL_MAX;
                        state_d = StHoldHi;
                        hold_d  = 8'd0;
                    end else begin
                        lvl_d = lvl_q + LVL_ONE;
                    end
                end
                StHoldHi: begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = StDown;
                        hold_d  = 8'd0;
                    end else begin
                        hold_d = hold_q + 8'd1;
                    end
                end
                StDown: begin
                    if (blink || (lvl_q == LVL_ONE)) begin
                        lvl_d   = '0;
                        state_d = StHoldLo;
                        hold_d  = 8'd0;
                    end else begin
                        lvl_d = lvl_q - LVL_ONE;
                    end
                end
                StHoldLo: begin
                    if (hold_q == HOLD_LAST) begin
                        cnt_d  = cnt_q + 4'd1;
                        hold_d = 8'd0;
                        if ((rep_q != 4'd0) && (cnt_d == rep_q)) begin
                            state_d = StIdle;
                            lvl_d   = '0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = StUp;
                        end
                    end else begin
                        hold_d = hold_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge osc or posedge sys_rst) begin
        if (sys_rst) begin
            state_q  <= StIdle;
            lvl_q    <= '0;
            pwm_q    <= '0;
            presc_q  <= PRESC_RELOAD;
            cnt_q    <= 4'd0;
            hold_q   <= 8'd0;
            color_q  <= 2'd0;
            mode_q   <= 2'd0;
            rep_q    <= 4'd0;
            done_q   <= 1'b0;
            red_q    <= 1'b1;
            green_q  <= 1'b1;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lvl_q    <= lvl_d;
            pwm_q    <= pwm_q + LVL_ONE;
            presc_q  <= presc_d;
            cnt_q    <= cnt_d;
            hold_q   <= hold_d;
            color_q  <= color_d;
            mode_q   <= mode_d;
            rep_q    <= rep_d;
            done_q   <= done_d;
            red_q    <= red_d;
            green_q  <= green_d;
            rdy_en_q <= 1'b1;
        end
    end

endmodule
